// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I/RV64I integer core: one stage per clock through
// FETCH/DECODE/EXECUTE/WRITEBACK, with local instruction memory and register file.
module multi_cycle_core #(
  parameter int          XLEN       = 32,
  parameter int          IMEM_DEPTH = 64,
  parameter int          NUM_REGS   = 32,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [4:0]                    dbg_raddr,
  output logic [XLEN-1:0]               dbg_rdata,
  output logic [XLEN-1:0]               pc,
  output logic                          busy,
  output logic                          halted,
  output logic [1:0]                    halt_cause,
  output logic                          retire_valid,
  output logic [4:0]                    retire_rd,
  output logic [XLEN-1:0]               retire_data
);

  localparam int unsigned AW  = $clog2(IMEM_DEPTH);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned RW  = $clog2(NUM_REGS);
  localparam int unsigned NR  = NUM_REGS;
  localparam logic [5:0]      NREG = 6'(NUM_REGS);
  localparam logic [XLEN-1:0] PC0  = XLEN'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [1:0]      cause_q, cause_d;

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] rf_q [NUM_REGS];

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm;
  logic            is_r, is_i, upper_zero, legal, fetch_fault;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm    = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  // Shift-immediate upper field: bit 30 is the SRAI selector, all other bits above shamt must be 0.
  assign upper_zero = ({ir_q[31], ir_q[29:20+SHW]} == '0);
  assign fetch_fault = (pc_q[1:0] != 2'b00) || ((pc_q >> 2) >= XLEN'(IMEM_DEPTH));
  assign shamt = opb_q[SHW-1:0];

  always_comb begin
    legal = 1'b0;
    if (is_r) begin
      legal = (funct7 == 7'b0000000) ||
              (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5));
    end else if (is_i) begin
      if (funct3 == 3'd1)      legal = upper_zero && !ir_q[30];
      else if (funct3 == 3'd5) legal = upper_zero;
      else                     legal = 1'b1;
    end
    if ({1'b0, rd} >= NREG || {1'b0, rs1} >= NREG || (is_r && {1'b0, rs2} >= NREG))
      legal = 1'b0;
  end

  always_comb begin
    alu = '0;
    unique case (funct3)
      3'd0: alu = (is_r && ir_q[30]) ? opa_q - opb_q : opa_q + opb_q;
      3'd1: alu = opa_q << shamt;
      3'd2: alu = {{(XLEN-1){1'b0}}, $signed(opa_q) < $signed(opb_q)};
      3'd3: alu = {{(XLEN-1){1'b0}}, opa_q < opb_q};
      3'd4: alu = opa_q ^ opb_q;
      3'd5: begin
        if (ir_q[30]) alu = $signed(opa_q) >>> shamt;
        else          alu = opa_q >> shamt;
      end
      3'd6: alu = opa_q | opb_q;
      3'd7: alu = opa_q & opb_q;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = PC0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_fault) begin
          cause_d = 2'd2;
          state_d = S_HALT;
        end else begin
          ir_d    = imem[pc_q[AW+1:2]];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          cause_d = 2'd1;
          state_d = S_HALT;
        end else begin
          opa_d   = rf_q[rs1[RW-1:0]];
          opb_d   = is_r ? rf_q[rs2[RW-1:0]] : imm;
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        res_d   = alu;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + XLEN'(4);
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          cause_d = 2'd0;
          pc_d    = PC0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC0;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR; i++) rf_q[i] <= '0;
    end else if (state_q == S_WRITEBACK && rd != 5'd0) begin
      rf_q[rd[RW-1:0]] <= res_q;
    end
  end

  // Program memory has no reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (imem_we && (state_q == S_IDLE || state_q == S_HALT))
      imem[imem_waddr] <= imem_wdata;
  end

  assign dbg_rdata    = (dbg_raddr == 5'd0 || {1'b0, dbg_raddr} >= NREG) ? '0
                                                                         : rf_q[dbg_raddr[RW-1:0]];
  assign pc           = pc_q;
  assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign halted       = (state_q == S_HALT);
  assign halt_cause   = cause_q;
  assign retire_valid = (state_q == S_WRITEBACK);
  assign retire_rd    = rd;
  assign retire_data  = res_q;

endmodule

// File: tb/tb_multi_cycle_core.sv
// Bench for multi_cycle_core: a default instance and a small one (4-word imem,
// 16 registers), both checked against an instruction-level reference model.
module tb_multi_cycle_core;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, imem_we = 1'b0, sel = 1'b0;
  logic [5:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [4:0]  dbg_raddr = '0;

  logic        start_m, start_s, we_m, we_s;
  logic [31:0] dbg_m, dbg_s, pc_m, pc_s, rdata_m, rdata_s;
  logic        busy_m, busy_s, halted_m, halted_s, rv_m, rv_s;
  logic [1:0]  cause_m, cause_s;
  logic [4:0]  rd_m, rd_s;

  logic [31:0] o_dbg, o_pc, o_rdata;
  logic        o_busy, o_halted, o_rv;
  logic [1:0]  o_cause;
  logic [4:0]  o_rd;

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] prog  [64];
  logic [31:0] mregs [32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start_m = start && !sel;
  assign start_s = start && sel;
  assign we_m    = imem_we && !sel;
  assign we_s    = imem_we && sel;

  multi_cycle_core #(.XLEN(32), .IMEM_DEPTH(64), .NUM_REGS(32), .RESET_PC(0)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start_m), .imem_we(we_m), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_m), .pc(pc_m),
    .busy(busy_m), .halted(halted_m), .halt_cause(cause_m), .retire_valid(rv_m),
    .retire_rd(rd_m), .retire_data(rdata_m));

  multi_cycle_core #(.XLEN(32), .IMEM_DEPTH(4), .NUM_REGS(16), .RESET_PC(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .imem_we(we_s), .imem_waddr(imem_waddr[1:0]),
    .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_s), .pc(pc_s),
    .busy(busy_s), .halted(halted_s), .halt_cause(cause_s), .retire_valid(rv_s),
    .retire_rd(rd_s), .retire_data(rdata_s));

  assign o_dbg    = sel ? dbg_s    : dbg_m;
  assign o_pc     = sel ? pc_s     : pc_m;
  assign o_rdata  = sel ? rdata_s  : rdata_m;
  assign o_busy   = sel ? busy_s   : busy_m;
  assign o_halted = sel ? halted_s : halted_m;
  assign o_rv     = sel ? rv_s     : rv_m;
  assign o_cause  = sel ? cause_s  : cause_m;
  assign o_rd     = sel ? rd_s     : rd_m;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd  = 5'($urandom);
    logic [4:0]  rs1 = 5'($urandom);
    logic [4:0]  rs2 = 5'($urandom);
    logic [2:0]  f3  = 3'($urandom);
    int unsigned k   = $urandom_range(0, 15);
    logic [6:0]  f7;
    if (k < 12)                               f7 = 7'h00;
    else if (k < 15 && (f3 == 0 || f3 == 5))  f7 = 7'h20;
    else if (k < 15)                          f7 = 7'h00;
    else                                      f7 = 7'($urandom);
    if ($urandom_range(0, 1) == 0) return enc_r(f7, rs2, rs1, f3, rd);
    if (f3 == 3'd1 || f3 == 3'd5) return enc_i({f7, rs2}, rs1, f3, rd);
    return enc_i(12'($urandom), rs1, f3, rd);
  endfunction

  // Instruction-level model: returns 1 and the result for a legal instruction.
  function automatic bit model_exec(input logic [31:0] ins, input int nregs, output logic [31:0] res);
    logic [6:0]  op  = ins[6:0];
    logic [2:0]  f3  = ins[14:12];
    logic [6:0]  f7  = ins[31:25];
    int          rd  = int'(ins[11:7]);
    int          rs1 = int'(ins[19:15]);
    int          rs2 = int'(ins[24:20]);
    logic [31:0] a, b;
    int unsigned sh;
    res = '0;
    if (op != 7'h33 && op != 7'h13) return 0;
    if (rd >= nregs || rs1 >= nregs) return 0;
    a = mregs[rs1];
    if (op == 7'h33) begin
      if (rs2 >= nregs) return 0;
      if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) return 0;
      b = mregs[rs2];
    end else begin
      b = {{20{ins[31]}}, ins[31:20]};
      if (f3 == 3'd1 && f7 != 7'h00) return 0;
      if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return 0;
    end
    sh = int'(b[4:0]);
    case (f3)
      3'd0: res = (op == 7'h33 && f7 == 7'h20) ? a - b : a + b;
      3'd1: res = a << sh;
      3'd2: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: res = (a < b) ? 32'd1 : 32'd0;
      3'd4: res = a ^ b;
      3'd5: res = (a >> sh) | ((f7 == 7'h20 && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    return 1;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  task automatic load_prog();
    int depth = sel ? 4 : 64;
    for (int i = 0; i < depth; i++) begin
      @(negedge clk);
      imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = prog[i];
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endtask

  // Starts the core and follows the program in the model until it halts.
  // poke: pulse start and write imem while busy; both must be ignored.
  task automatic run_prog(input string name, input bit poke);
    int          depth = sel ? 4 : 64;
    int          nregs = sel ? 16 : 32;
    logic [31:0] mpc = 32'h0, ins, res;
    logic [1:0]  exp_cause = 2'd0;
    int          ref_c, n;
    bit          spur = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; ref_c = cyc;
    if (poke) begin
      start = 1'b1; imem_we = 1'b1; imem_waddr = 6'd1; imem_wdata = 32'h0;
    end
    for (int step = 0; step < 100; step++) begin
      if (mpc[1:0] != 2'b00 || int'(mpc >> 2) >= depth) begin exp_cause = 2'd2; break; end
      ins = prog[mpc[7:2]];
      if (!model_exec(ins, nregs, res)) begin exp_cause = 2'd1; break; end
      n = 0;
      while (o_rv !== 1'b1 && n < 8) begin
        @(negedge clk); n++;
        if (n == 2) begin start = 1'b0; imem_we = 1'b0; end
      end
      checks++;
      if (o_rv !== 1'b1) begin
        failures++;
        $display("FAIL %s retire_timeout step=%0d got=none want rd=%0d data=%h", name, step, ins[11:7], res);
        return;
      end
      if (o_rd !== ins[11:7] || o_rdata !== res || cyc != ref_c + 3) begin
        failures++;
        $display("FAIL %s retire step=%0d got rd=%0d data=%h cyc=%0d want rd=%0d data=%h cyc=%0d",
                 name, step, o_rd, o_rdata, cyc, ins[11:7], res, ref_c + 3);
      end
      if (ins[11:7] != 5'd0) mregs[ins[11:7]] = res;
      mpc += 32'd4;
      ref_c += 4;
      @(negedge clk);
    end
    start = 1'b0; imem_we = 1'b0;
    n = 0;
    while (o_halted !== 1'b1 && n < 8) begin
      if (o_rv === 1'b1) spur = 1;
      @(negedge clk); n++;
    end
    checks++;
    if (o_halted !== 1'b1 || o_cause !== exp_cause || o_pc !== mpc || spur ||
        cyc != ref_c + ((exp_cause == 2'd2) ? 1 : 2)) begin
      failures++;
      $display("FAIL %s halt got halted=%b cause=%0d pc=%h cyc=%0d spurious_retire=%0d want halted=1 cause=%0d pc=%h cyc=%0d",
               name, o_halted, o_cause, o_pc, cyc, spur, exp_cause, mpc,
               ref_c + ((exp_cause == 2'd2) ? 1 : 2));
    end
  endtask

  task automatic check_regs(input string name);
    int nregs = sel ? 16 : 32;
    logic [31:0] exp;
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = 5'(i); #1;
      exp = (i == 0 || i >= nregs) ? 32'h0 : mregs[i];
      checks++;
      if (o_dbg !== exp) begin
        failures++;
        $display("FAIL %s dbg x%0d got=%h want=%h", name, i, o_dbg, exp);
      end
    end
  endtask

  task automatic check_reg(input string name, input int idx, input logic [31:0] exp);
    dbg_raddr = 5'(idx); #1;
    checks++;
    if (o_dbg !== exp) begin
      failures++;
      $display("FAIL %s x%0d got=%h want=%h", name, idx, o_dbg, exp);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; rst_n = 1'b0; #1;
    checks++;
    if (o_busy !== 1'b0 || o_halted !== 1'b0 || o_rv !== 1'b0 || o_cause !== 2'd0 ||
        o_pc !== 32'h0 || o_rd !== 5'd0 || o_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b halted=%b rv=%b cause=%0d pc=%h rd=%0d data=%h want all 0",
               o_busy, o_halted, o_rv, o_cause, o_pc, o_rd, o_rdata);
    end
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    check_regs("reset_regs");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b halted=%b want busy=0 halted=0", o_busy, o_halted);
    end
  endtask

  task automatic load_plan();
    clear_prog();
    prog[0] = 32'h0050_0093; prog[1] = 32'hFFD0_0113; prog[2] = 32'h0020_81B3; prog[3] = 32'h0;
  endtask

  task automatic test_plan();
    sel = 1'b0;
    load_plan(); load_prog();
    run_prog("plan", 0);
    check_reg("plan", 1, 32'd5);
    check_reg("plan", 2, 32'hFFFF_FFFD);
    check_reg("plan", 3, 32'd2);
    checks++;
    if (o_cause !== 2'd1 || o_pc !== 32'd12) begin
      failures++;
      $display("FAIL plan_halt got cause=%0d pc=%h want cause=1 pc=0000000c", o_cause, o_pc);
    end
  endtask

  task automatic test_shifts();
    sel = 1'b0;
    clear_prog();
    prog[0] = 32'h4011_5213; prog[1] = 32'h01C1_5293; prog[2] = 32'h0011_2333;
    prog[3] = 32'h0011_33B3; prog[4] = 32'h0070_0013;
    load_prog();
    run_prog("shifts", 0);
    check_reg("shifts", 4, 32'hFFFF_FFFE);
    check_reg("shifts", 5, 32'h0000_000F);
    check_reg("shifts", 6, 32'd1);
    check_reg("shifts", 7, 32'd0);
    check_reg("shifts", 0, 32'd0);
    check_regs("shifts_all");
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int r = 0; r < 4; r++) begin
      clear_prog();
      for (int i = 0; i < 24; i++) prog[i] = rand_instr();
      load_prog();
      run_prog("random", 0);
      check_regs("random_regs");
    end
  endtask

  task automatic test_reset_midrun();
    sel = 1'b0;
    load_plan(); load_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_busy got=%b want=1", o_busy);
    end
    #2 rst_n = 1'b0; #1;
    checks++;
    if (o_busy !== 1'b0 || o_halted !== 1'b0 || o_rv !== 1'b0 || o_cause !== 2'd0 ||
        o_pc !== 32'h0 || o_rd !== 5'd0 || o_rdata !== 32'h0) begin
      failures++;
      $display("FAIL midrun_reset got busy=%b halted=%b rv=%b cause=%0d pc=%h rd=%0d data=%h want all 0",
               o_busy, o_halted, o_rv, o_cause, o_pc, o_rd, o_rdata);
    end
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    check_regs("midrun_regs");
    @(negedge clk); rst_n = 1'b1;
    run_prog("midrun_rerun", 0);
    check_regs("midrun_rerun_regs");
  endtask

  task automatic test_small();
    sel = 1'b1;
    do_reset();
    clear_prog();
    prog[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1);
    prog[1] = enc_i(12'd2, 5'd1, 3'd0, 5'd2);
    prog[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    prog[3] = enc_i(12'hFFF, 5'd3, 3'd0, 5'd15);
    load_prog();
    run_prog("small_pcfault", 0);
    checks++;
    if (o_cause !== 2'd2 || o_pc !== 32'd16) begin
      failures++;
      $display("FAIL small_pcfault_const got cause=%0d pc=%h want cause=2 pc=00000010", o_cause, o_pc);
    end
    run_prog("small_restart_busy_poke", 1);
    check_regs("small_regs");
    prog[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd20);
    load_prog();
    run_prog("small_illegal_rd", 0);
    checks++;
    if (o_cause !== 2'd1 || o_pc !== 32'd0) begin
      failures++;
      $display("FAIL small_illegal_const got cause=%0d pc=%h want cause=1 pc=00000000", o_cause, o_pc);
    end
    check_regs("small_regs_after_illegal");
  endtask

  initial begin
    test_reset();
    test_plan();
    test_shifts();
    test_random();
    test_reset_midrun();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_core.md
# multi_cycle_core

Parametrised multi-cycle RV32I/RV64I integer core that supersedes the single-cycle top. It sequences fetch, decode, execute and writeback through an explicit state machine, one stage per clock. It contains its own instruction memory, register file, immediate generator and ALU. The core executes the R-type and I-type ALU subset, reports every retirement, and halts cleanly on illegal instructions or an out-of-range PC.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- IMEM_DEPTH, 64: instruction memory depth in 32-bit words.
- NUM_REGS, 32: architectural registers; legal values 16 (E-variant) or 32.
- RESET_PC, 0: byte address of the first instruction; must be word aligned.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, active-low; asynchronous assert, synchronous release.
- start  in  1  run pulse; honoured only in IDLE or HALT.
- imem_we  in  1  program-load write strobe; honoured only in IDLE or HALT.
- imem_waddr  in  $clog2(IMEM_DEPTH)  word address for the program load.
- imem_wdata  in  32  instruction word to write.
- dbg_raddr  in  5  debug register read index.
- dbg_rdata  out  XLEN  combinational register read; returns 0 for index 0 or index >= NUM_REGS.
- pc  out  XLEN  byte address of the instruction in flight.
- busy  out  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
- halted  out  1  high in HALT.
- halt_cause  out  2  0 = none, 1 = illegal instruction, 2 = PC out of range; held while in HALT.
- retire_valid  out  1  high for exactly the WRITEBACK cycle.
- retire_rd  out  5  destination index of the retiring instruction.
- retire_data  out  XLEN  result of the retiring instruction; valid even when rd = 0.

## Operation
- States are IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
- IDLE: if start, load pc with RESET_PC and go to FETCH.
- FETCH:
  - If pc[1:0] != 0 or pc>>2 >= IMEM_DEPTH, set halt_cause = 2 and go to HALT.
  - Otherwise register imem[pc>>2] into the instruction register and go to DECODE.
- DECODE:
  - Check the opcode, funct3/funct7 and register indices.
  - Any unsupported encoding, or any rd/rs1/rs2 >= NUM_REGS, sets halt_cause = 1 and goes to HALT.
  - Otherwise latch the rs1 and rs2 operands and the sign-extended I-immediate, then go to EXECUTE.
- Supported opcode 0110011 (R-type): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. funct7 must be 0000000, or 0100000 for SUB and SRA only.
- Supported opcode 0010011 (I-type): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Shift immediates use imm[$clog2(XLEN)-1:0].
  - The upper immediate bits must be 0, or 0100000 for SRAI only.
- EXECUTE: compute the ALU result into a result register, then go to WRITEBACK.
  - Arithmetic is modulo 2^XLEN.
  - Shift amounts use the low $clog2(XLEN) bits.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned (immediate sign-extended first). Result is 1 or 0.
- WRITEBACK: retire_valid = 1. On the closing edge:
  - Write the result to rd, unless rd = 0 (x0 stays 0).
  - Set pc to pc+4 and go to FETCH.
- HALT: hold all registers. On start, clear halt_cause, load RESET_PC and go to FETCH.
- Program loading:
  - imem_we writes in IDLE or HALT; it is ignored while busy.
  - imem is not reset and keeps its contents across rst_n.
- start while busy is ignored.

## Timing
- Reset values:
  - State IDLE, pc = RESET_PC, all registers 0.
  - busy, halted, retire_valid and halt_cause all 0; retire_rd = 0, retire_data = 0.
- If start is sampled at edge N, FETCH occupies cycle N+1, DECODE N+2, EXECUTE N+3 and WRITEBACK N+4.
- The register file update is visible on dbg_rdata in cycle N+5.
- Throughput is one instruction per 4 cycles. A halt is entered 1 cycle (FETCH fault) or 2 cycles (DECODE fault) after the stage begins.
- Illegal instructions and PC faults do not retire and do not write the register file.
- An rst_n assertion in any state aborts immediately and restores the reset values above. imem contents are preserved.
- Register reads in DECODE see all prior writes, because the writeback of the previous instruction has completed. No bypass is needed.

## Test plan
- Load 0x00500093, 0xFFD00113, 0x002081B3, 0x00000000, then start → three retire pulses 4 cycles apart with (rd, data) = (1,5), (2,0xFFFF_FFFD), (3,2); then halted = 1, halt_cause = 1, pc = 12.
- SRAI x4,x2,1 and SRLI x5,x2,28 with x2 = -3 → x4 = 0xFFFF_FFFE, x5 = 0xF; SLT x6,x2,x1 → 1; SLTU x7,x2,x1 → 0.
- ADDI x0,x0,7 → retire_valid = 1 with retire_data = 7; dbg read of x0 returns 0.
- IMEM_DEPTH = 4, four legal instructions → 4 retires, then halt_cause = 2 with pc = 16. Then start → execution restarts at RESET_PC.
- NUM_REGS = 16, ADDI x20,x0,1 → halt_cause = 1, no retire. imem_we while busy → memory unchanged.
- Assert rst_n low during EXECUTE → all outputs and registers zero in the same cycle; the program survives, and a new start reruns it identically.
